// File: rtl/calc_operand_sequencer.sv
// Serial operand feeder and result capture stage for the six-operand calculator.
// Gathers one burst of nibbles, holds them on the calculator, then registers the result.
module calc_operand_sequencer #(
  parameter int unsigned NUM_OPS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic [2:0] in_opt,
  input  logic       in_equ,
  output logic [3:0] calc_n0,
  output logic [3:0] calc_n1,
  output logic [3:0] calc_n2,
  output logic [3:0] calc_n3,
  output logic [3:0] calc_n4,
  output logic [3:0] calc_n5,
  output logic [2:0] calc_opt,
  output logic       calc_equ,
  input  logic [9:0] calc_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] out_data
);

  typedef enum logic [1:0] {StIdle, StLoad, StCalc, StHold} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] ops_q [NUM_OPS];
  logic [2:0] opt_q;
  logic       equ_q;
  logic       out_valid_q;
  logic [9:0] out_data_q;

  logic load_first;
  logic load_beat;
  logic capture;
  logic out_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    load_first = 1'b0;
    load_beat  = 1'b0;
    capture    = 1'b0;
    out_clr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_first = 1'b1;
          cnt_d      = 3'd1;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_beat = 1'b1;
          cnt_d     = cnt_q + 3'd1;
          if (cnt_q == 3'(NUM_OPS - 1)) begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        capture = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (out_ready) begin
          out_clr = 1'b1;
          cnt_d   = 3'd0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Operand registers only move on accepted beats, so they stay stable through CALC and HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        ops_q[i] <= 4'd0;
      end
      opt_q <= 3'd0;
      equ_q <= 1'b0;
    end else if (load_first) begin
      ops_q[0] <= in_data;
      opt_q    <= in_opt;
      equ_q    <= in_equ;
    end else if (load_beat) begin
      for (int i = 1; i < NUM_OPS; i++) begin
        if (cnt_q == 3'(i)) begin
          ops_q[i] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 10'd0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
      out_data_q  <= calc_out;
    end else if (out_clr) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 10'd0;
    end
  end

  assign calc_n0   = ops_q[0];
  assign calc_n1   = ops_q[1];
  assign calc_n2   = ops_q[2];
  assign calc_n3   = ops_q[3];
  assign calc_n4   = ops_q[4];
  assign calc_n5   = ops_q[5];
  assign calc_opt  = opt_q;
  assign calc_equ  = equ_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Bench for calc_operand_sequencer: directed burst table, reset and backpressure
// sequences, then random traffic against a beat-counting reference model.
module tb_calc_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [2:0] in_opt;
  logic       in_equ;
  logic [3:0] calc_n0, calc_n1, calc_n2, calc_n3, calc_n4, calc_n5;
  logic [2:0] calc_opt;
  logic       calc_equ;
  logic [9:0] calc_out;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_operand_sequencer #(.NUM_OPS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_opt   (in_opt),
    .in_equ   (in_equ),
    .calc_n0  (calc_n0),
    .calc_n1  (calc_n1),
    .calc_n2  (calc_n2),
    .calc_n3  (calc_n3),
    .calc_n4  (calc_n4),
    .calc_n5  (calc_n5),
    .calc_opt (calc_opt),
    .calc_equ (calc_equ),
    .calc_out (calc_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  // Stand-in calculator: equ=1 gives n0+n3, equ=0 gives (n2+n3*n3)*n4/n2; opt folds into top bits.
  function automatic logic [9:0] calc_fn(logic [3:0] n0, logic [3:0] n2, logic [3:0] n3,
                                         logic [3:0] n4, logic [2:0] o, logic e);
    int base;
    if (e) base = int'(n0) + int'(n3);
    else if (n2 == 4'd0) base = 0;
    else base = ((int'(n2) + int'(n3) * int'(n3)) * int'(n4)) / int'(n2);
    return 10'(base) ^ {o, 7'b0};
  endfunction

  assign calc_out = calc_fn(calc_n0, calc_n2, calc_n3, calc_n4, calc_opt, calc_equ);

  // Reference model: a count of beats taken, the operands seen, and a pending-result flag.
  logic [3:0] m_ops [6];
  logic [2:0] m_opt;
  logic       m_equ;
  int         m_beats;
  bit         m_hold;
  logic [9:0] m_out;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_ops[i] = 4'd0;
    m_opt = 3'd0; m_equ = 1'b0; m_beats = 0; m_hold = 0; m_out = 10'd0;
  endtask

  task automatic model_edge(logic v, logic [3:0] d, logic [2:0] o, logic e, logic r);
    if (m_hold) begin
      if (r) begin
        m_hold = 0; m_out = 10'd0; m_beats = 0;
      end
    end else if (m_beats == 6) begin
      m_hold = 1;
      m_out  = calc_fn(m_ops[0], m_ops[2], m_ops[3], m_ops[4], m_opt, m_equ);
    end else if (v) begin
      m_ops[m_beats] = d;
      if (m_beats == 0) begin
        m_opt = o; m_equ = e;
      end
      m_beats++;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    logic [3:0] dn [6];
    dn[0] = calc_n0; dn[1] = calc_n1; dn[2] = calc_n2;
    dn[3] = calc_n3; dn[4] = calc_n4; dn[5] = calc_n5;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_beats < 6));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_hold));
    chk({tag, ".out_data"}, 32'(out_data), 32'(m_out));
    chk({tag, ".calc_opt"}, 32'(calc_opt), 32'(m_opt));
    chk({tag, ".calc_equ"}, 32'(calc_equ), 32'(m_equ));
    for (int i = 0; i < 6; i++) chk({tag, ".calc_n"}, 32'(dn[i]), 32'(m_ops[i]));
  endtask

  task automatic check_reset(string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_data"}, 32'(out_data), 32'd0);
    chk({tag, ".calc_opt"}, 32'(calc_opt), 32'd0);
    chk({tag, ".calc_equ"}, 32'(calc_equ), 32'd0);
    chk({tag, ".calc_n"}, {8'd0, calc_n5, calc_n4, calc_n3, calc_n2, calc_n1, calc_n0}, 32'd0);
  endtask

  // Called at a negedge: drive, predict the coming edge, then check at the next negedge.
  task automatic step(string tag, logic v, logic [3:0] d, logic [2:0] o, logic e, logic r);
    in_valid = v; in_data = d; in_opt = o; in_equ = e; out_ready = r;
    model_edge(v, d, o, e, r);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic send_burst(string tag, logic [23:0] nibs, logic [2:0] o, logic e,
                            bit gap, bit late);
    for (int i = 0; i < 6; i++) begin
      if (gap && i == 2) begin
        for (int g = 0; g < 3; g++) step({tag, ".gap"}, 1'b0, 4'hA, 3'd7, ~e, 1'b1);
      end
      step({tag, ".beat"}, 1'b1, nibs[4*i +: 4], (late && i > 0) ? 3'b111 : o,
           (i > 0) ? ~e : e, 1'b1);
    end
  endtask

  task automatic async_reset(string tag);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_model({tag, ".after"});
  endtask

  typedef struct packed {
    logic [23:0] nibs;
    logic [2:0]  opt;
    logic        equ;
    bit          gap;
    bit          late;
    logic [9:0]  exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{nibs: 24'h654321, opt: 3'b000, equ: 1'b1, gap: 1'b0, late: 1'b0, exp: 10'd5};
    vecs[1] = '{nibs: 24'h654321, opt: 3'b000, equ: 1'b0, gap: 1'b0, late: 1'b0, exp: 10'd31};
    vecs[2] = '{nibs: 24'h654321, opt: 3'b000, equ: 1'b1, gap: 1'b1, late: 1'b1, exp: 10'd5};
    vecs[3] = '{nibs: 24'h37920F, opt: 3'b101, equ: 1'b0, gap: 1'b0, late: 1'b0, exp: 10'd930};
    vecs[4] = '{nibs: 24'h01C789, opt: 3'b010, equ: 1'b1, gap: 1'b1, late: 1'b0, exp: 10'd277};

    rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; in_opt = 3'd0; in_equ = 1'b0;
    out_ready = 1'b0;
    #1 check_reset("por");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_model("idle");

    foreach (vecs[v]) begin
      send_burst("vec", vecs[v].nibs, vecs[v].opt, vecs[v].equ, vecs[v].gap, vecs[v].late);
      // Edge k+1: result captured.
      step("vec.calc", 1'b0, 4'd0, 3'd0, 1'b0, 1'b1);
      chk("vec.valid_k1", 32'(out_valid), 32'd1);
      chk("vec.result", 32'(out_data), 32'(vecs[v].exp));
      chk("vec.opt_first", 32'(calc_opt), 32'(vecs[v].opt));
      // Edge k+2: handshake completes.
      step("vec.hold", 1'b0, 4'd0, 3'd0, 1'b0, 1'b1);
      chk("vec.valid_k2", 32'(out_valid), 32'd0);
      chk("vec.ready_k2", 32'(in_ready), 32'd1);
    end

    // Backpressure with upstream pushing the whole time.
    send_burst("bp", 24'h654321, 3'b000, 1'b0, 1'b0, 1'b0);
    step("bp.calc", 1'b1, 4'h9, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step("bp.hold", 1'b1, 4'(i), 3'd3, 1'b1, 1'b0);
      chk("bp.stable", 32'(out_data), 32'd31);
      chk("bp.no_ready", 32'(in_ready), 32'd0);
    end
    step("bp.release", 1'b1, 4'hE, 3'd4, 1'b1, 1'b1);
    step("bp.first_beat", 1'b1, 4'hE, 3'd4, 1'b1, 1'b1);
    chk("bp.new_opt", 32'(calc_opt), 32'd4);
    for (int i = 1; i < 6; i++) step("bp.rest", 1'b1, 4'(i), 3'd0, 1'b0, 1'b1);
    step("bp.calc2", 1'b0, 4'd0, 3'd0, 1'b0, 1'b1);
    step("bp.hold2", 1'b0, 4'd0, 3'd0, 1'b0, 1'b1);

    // Reset after three beats of a burst.
    for (int i = 0; i < 3; i++) step("rl.beat", 1'b1, 4'(i + 7), 3'd5, 1'b1, 1'b1);
    async_reset("rst_load");
    step("rl.first", 1'b1, 4'h3, 3'b110, 1'b0, 1'b1);
    chk("rl.opt", 32'(calc_opt), 32'd6);
    for (int i = 1; i < 6; i++) step("rl.rest", 1'b1, 4'(i), 3'd1, 1'b1, 1'b1);
    step("rl.calc", 1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
    step("rl.hold", 1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
    chk("rl.pending", 32'(out_valid), 32'd1);
    // Reset with a result pending.
    async_reset("rst_hold");
    send_burst("rh", 24'h123456, 3'b011, 1'b1, 1'b0, 1'b0);
    chk("rh.opt", 32'(calc_opt), 32'd3);

    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom), 3'($urandom),
           1'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
